i2s_tx_bridge: RTL and testbench

Parametrised stereo I2S transmit bridge: accepts left/right sample pairs from the system side through a valid/ready write port and buffers them in an internal frame FIFO. It serialises them as standard I2S (MSB one bit-clock after the LR transition) and generates m_clk, s_clk and LR_clk from `clk` by programmable division. It also adds mono duplication, underrun detection and a fill-level report. It replaces the fixed 16-bit, single-sample speaker path between sample memory and the codec pins.

---
 rtl/i2s_tx_bridge_if.sv | 25 ++
 rtl/i2s_tx_bridge.sv | 143 ++++++++++++++
 tb/tb_i2s_tx_bridge.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_bridge_if.sv
// Write-side port of the I2S transmit bridge: producer pushes stereo
// sample pairs, bridge reports back-pressure and FIFO fill level.
interface i2s_tx_bridge_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] l_data;
  logic [DATA_W-1:0] r_data;
  logic              mono;
  logic              wr_valid;
  logic              wr_ready;
  logic [LVL_W-1:0]  level;

  modport master (
    output l_data, r_data, mono, wr_valid,
    input  wr_ready, level
  );

  modport slave (
    input  l_data, r_data, mono, wr_valid,
    output wr_ready, level
  );
endinterface

// File: rtl/i2s_tx_bridge.sv
// Stereo I2S transmitter with a frame FIFO on the system side.
// m_clk, s_clk and LR_clk are divided down from clk; the serialiser runs
// continuously and sends zero frames (flagging underrun) when starved.
module i2s_tx_bridge #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MCLK_HALF  = 2,
  parameter int SCLK_HALF  = 8
) (
  input  logic              clk,
  input  logic              rst,
  i2s_tx_bridge_if.slave    wr,
  output logic              m_clk,
  output logic              s_clk,
  output logic              LR_clk,
  output logic              data_out,
  output logic              DONE,
  output logic              underrun
);
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int POS_W   = $clog2(FRAME_W);
  localparam int MC_W    = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SC_W    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int PAD     = SLOT_W - DATA_W;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level_q;
  logic [MC_W-1:0]     m_cnt;
  logic [SC_W-1:0]     s_cnt;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_next;
  logic [FRAME_W-1:0]  shreg;
  logic [FRAME_W-1:0]  new_frame;
  logic [2*DATA_W-1:0] head;
  logic [SLOT_W-1:0]   l_slot;
  logic [SLOT_W-1:0]   r_slot;
  logic                fall_evt;
  logic                frame_start;
  logic                push;
  logic                pop;

  // Back-pressure comes only from the registered level, so a pop in the
  // same cycle never frees a slot for a simultaneous push.
  assign wr.wr_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign wr.level    = level_q;
  assign push        = wr.wr_valid && wr.wr_ready;

  // Frame-position and FIFO-head decode shared by the serialiser and FIFO.
  always_comb begin
    fall_evt    = s_clk && (s_cnt == SC_W'(SCLK_HALF - 1));
    pos_next    = (pos == POS_W'(FRAME_W - 1)) ? '0 : pos + POS_W'(1);
    frame_start = fall_evt && (pos_next == '0);
    pop         = frame_start && (level_q != '0);
    head        = mem[rd_ptr];
    l_slot      = SLOT_W'(head[2*DATA_W-1:DATA_W]) << PAD;
    r_slot      = SLOT_W'(head[DATA_W-1:0]) << PAD;
    new_frame   = pop ? {l_slot, r_slot} : '0;
  end

  // Free-running master clock divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt <= '0;
      m_clk <= 1'b0;
    end else if (m_cnt == MC_W'(MCLK_HALF - 1)) begin
      m_cnt <= '0;
      m_clk <= ~m_clk;
    end else begin
      m_cnt <= m_cnt + MC_W'(1);
    end
  end

  // Bit clock divider; its falling toggles pace the whole serialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_cnt <= '0;
      s_clk <= 1'b0;
    end else if (s_cnt == SC_W'(SCLK_HALF - 1)) begin
      s_cnt <= '0;
      s_clk <= ~s_clk;
    end else begin
      s_cnt <= s_cnt + SC_W'(1);
    end
  end

  // Serialiser: the MSB of the shift register goes out on each fall, so the
  // previous frame's LSB lands on p=0 and gives the I2S one-bit delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos      <= POS_W'(FRAME_W - 1);
      LR_clk   <= 1'b1;
      data_out <= 1'b0;
      shreg    <= '0;
      DONE     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      underrun <= 1'b0;
      if (fall_evt) begin
        pos      <= pos_next;
        LR_clk   <= (pos_next >= POS_W'(SLOT_W));
        data_out <= shreg[FRAME_W-1];
        if (frame_start) begin
          shreg    <= new_frame;
          DONE     <= pop;
          underrun <= !pop;
        end else begin
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  // Frame FIFO with occupancy counter; mono duplicates the left sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {wr.l_data, wr.mono ? wr.l_data : wr.r_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: tb/tb_i2s_tx_bridge.sv
// Bench for i2s_tx_bridge: a cycle-level reference model derives every
// expected output from the elapsed clk count and a queue of pushed frames.
module tb_i2s_tx_bridge;
  localparam int DATA_W      = 16;
  localparam int SLOT_W      = 32;
  localparam int SCLK_HALF   = 4;
  localparam int MCLK_HALF   = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int FRAME_W     = 2 * SLOT_W;
  localparam int FALL_PERIOD = 2 * SCLK_HALF;
  localparam int FRAME_CYC   = FRAME_W * FALL_PERIOD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_clk, s_clk, LR_clk, data_out, DONE, underrun;

  i2s_tx_bridge_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) wif ();

  i2s_tx_bridge #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MCLK_HALF(MCLK_HALF), .SCLK_HALF(SCLK_HALF)
  ) dut (
    .clk(clk), .rst(rst), .wr(wif.slave),
    .m_clk(m_clk), .s_clk(s_clk), .LR_clk(LR_clk),
    .data_out(data_out), .DONE(DONE), .underrun(underrun)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  int compares = 0;
  int fails    = 0;

  int               n;
  int               falls;
  int               cur_p;
  bit               fell;
  logic [31:0]      q[$];
  logic [FRAME_W-1:0] cur_f;
  logic             exp_lr, exp_do, exp_done, exp_under;
  logic             cap [FRAME_W];
  logic [15:0]      word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, n);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r,
                               input logic m);
    wif.wr_valid = v;
    wif.l_data   = l;
    wif.r_data   = r;
    wif.mono     = m;
  endtask

  task automatic modelEdge();
    logic [31:0] fr;
    bit          can_push;
    fell      = 0;
    exp_done  = 1'b0;
    exp_under = 1'b0;
    if (rst) begin
      n      = 0;
      falls  = 0;
      q.delete();
      cur_f  = '0;
      exp_lr = 1'b1;
      exp_do = 1'b0;
      return;
    end
    n++;
    can_push = wif.wr_valid && (q.size() < FIFO_DEPTH);
    if (n % FALL_PERIOD == 0) begin
      fell   = 1;
      falls++;
      cur_p  = (FRAME_W - 1 + falls) % FRAME_W;
      exp_lr = (cur_p >= SLOT_W);
      if (cur_p == 0) begin
        exp_do = cur_f[0];
        if (q.size() > 0) begin
          fr       = q.pop_front();
          cur_f    = {fr[31:16], 16'h0000, fr[15:0], 16'h0000};
          exp_done = 1'b1;
        end else begin
          cur_f     = '0;
          exp_under = 1'b1;
        end
      end else begin
        exp_do = cur_f[FRAME_W - cur_p];
      end
    end
    if (can_push) begin
      q.push_back({wif.l_data, wif.mono ? wif.l_data : wif.r_data});
    end
  endtask

  task automatic checkOutput();
    chk("m_clk",    m_clk,        64'((n / MCLK_HALF) % 2));
    chk("s_clk",    s_clk,        64'((n / SCLK_HALF) % 2));
    chk("LR_clk",   LR_clk,       exp_lr);
    chk("data_out", data_out,     exp_do);
    chk("DONE",     DONE,         exp_done);
    chk("underrun", underrun,     exp_under);
    chk("level",    wif.level,    64'(q.size()));
    chk("wr_ready", wif.wr_ready, 64'(q.size() != FIFO_DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
    if (fell) cap[cur_p] = data_out;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    chk("rst_m_clk",    m_clk,        0);
    chk("rst_s_clk",    s_clk,        0);
    chk("rst_LR_clk",   LR_clk,       1);
    chk("rst_data_out", data_out,     0);
    chk("rst_DONE",     DONE,         0);
    chk("rst_underrun", underrun,     0);
    chk("rst_level",    wif.level,    0);
    chk("rst_wr_ready", wif.wr_ready, 1);
    rst = 1'b0;
  endtask

  task automatic get_word(input int base, output logic [15:0] w);
    for (int i = 0; i < 16; i++) w[15-i] = cap[base + i];
  endtask

  initial begin
    n = 0;
    falls = 0;
    cur_p = 0;
    cur_f = '0;
    exp_lr = 1'b1;
    exp_do = 1'b0;
    exp_done = 1'b0;
    exp_under = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);

    $display("[TB] idle after reset");
    doReset();
    run_to(4);
    chk("s_clk_first_rise", s_clk, 1);
    run_to(7);
    chk("LR_before_fall", LR_clk, 1);
    run_to(8);
    chk("s_clk_first_fall", s_clk, 0);
    chk("LR_first_fall", LR_clk, 0);
    chk("idle_underrun", underrun, 1);
    run_to(80);

    $display("[TB] single stereo frame");
    doReset();
    applyStimulus(1'b1, 16'hA5C3, 16'h1234, 1'b0);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    run_to(8);
    chk("frame_DONE", DONE, 1);
    chk("frame_level", wif.level, 0);
    run_to(FALL_PERIOD * 50);
    get_word(1, word);
    chk("left_word", word, 16'hA5C3);
    get_word(17, word);
    chk("left_pad", word, 16'h0000);
    get_word(33, word);
    chk("right_word", word, 16'h1234);
    run_to(FALL_PERIOD + FRAME_CYC + 16);

    $display("[TB] mono frame");
    doReset();
    applyStimulus(1'b1, 16'h8001, 16'h7FFF, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    run_to(FALL_PERIOD * 50);
    get_word(1, word);
    chk("mono_left", word, 16'h8001);
    get_word(33, word);
    chk("mono_right", word, 16'h8001);

    $display("[TB] overflow and push/pop coincidence");
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      step();
      if (i == 3) begin
        chk("full_wr_ready", wif.wr_ready, 0);
        chk("full_level", wif.level, 4);
      end
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    chk("reject_level", wif.level, 4);
    run_to(8);
    chk("after_pop_ready", wif.wr_ready, 1);
    chk("after_pop_level", wif.level, 3);
    run_to(FALL_PERIOD + FRAME_CYC);
    chk("level_two", wif.level, 2);
    run_to(FALL_PERIOD + 2 * FRAME_CYC - 1);
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    chk("coincide_DONE", DONE, 1);
    chk("coincide_level", wif.level, 2);
    run_to(FALL_PERIOD + 2 * FRAME_CYC + 300);

    $display("[TB] reset mid-frame");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      step();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    run_to(41 * FALL_PERIOD + 2);
    chk("pre_reset_pos_LR", LR_clk, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_LR", LR_clk, 1);
    chk("mid_rst_s_clk", s_clk, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_level", wif.level, 0);
    chk("mid_rst_ready", wif.wr_ready, 1);
    rst = 1'b0;
    run_to(7);
    chk("restart_before_fall", s_clk, 1);
    run_to(8);
    chk("restart_fall_LR", LR_clk, 0);
    chk("restart_underrun", underrun, 1);

    $display("[TB] randomized traffic");
    doReset();
    while (n < FALL_PERIOD + 3 * FRAME_CYC) begin
      applyStimulus(1'($urandom % 16 == 0), 16'($urandom), 16'($urandom), 1'($urandom));
      step();
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    run_to(FALL_PERIOD + 4 * FRAME_CYC + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
